wrp_tdr_driver: RTL

- TDR-side initiator for a serial chain of wrapper boundary cells.
- On a start request it runs one access sequence: optional capture, then CHAIN_LEN shifts, then update.
- During the shifts it drives the chain serial input from a parallel load word and collects the chain serial output into a parallel read word.
- It generates the capture, shift, update and wrapper-enable strobes that the cells' clock gaters and muxes consume.
- It sits between the TAP/TDR decode logic and the first/last wrapper cell of a chain.

---
 rtl/wrp_tdr_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wrp_tdr_driver.sv
// TDR-side initiator for a serial chain of wrapper boundary cells.
// One access sequence is: optional capture, CHAIN_LEN shifts, then update and
// a one-cycle done pulse. Every output comes straight from a flop, so the
// strobes that gate the cell clocks cannot glitch.
module wrp_tdr_driver #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 TDR_TCK,
  input  logic                 TDR_TRESETN,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic                 wrp_dir,
  input  logic [CHAIN_LEN-1:0] wdata,
  input  logic                 chain_so,
  output logic                 chain_si,
  output logic                 TDR_CAPTURE,
  output logic                 TDR_SHIFT,
  output logic                 TDR_UPDATE,
  output logic                 INSCANWRAP_TDR_EN,
  output logic                 OUTSCANWRAP_TDR_EN,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT,
    ST_UPD,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic                 dir_q, dir_d;
  logic                 capture_q, capture_d;
  logic                 shift_q, shift_d;
  logic                 update_q, update_d;
  logic                 in_en_q, in_en_d;
  logic                 out_en_q, out_en_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state and datapath: the load word sits in a right-shifting register
  // so bit 0 leaves first, and received bits enter at the top so that after
  // CHAIN_LEN shifts the k-th received bit lands in position k.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d  = wdata;
          dir_d   = wrp_dir;
          cnt_d   = '0;
          state_d = capture_en ? ST_CAPT : ST_SHIFT;
        end
      end
      ST_CAPT: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cap_d  = CHAIN_LEN'({chain_so, cap_q} >> 1);
        sreg_d = sreg_q >> 1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_UPD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UPD: begin
        rdata_d = cap_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so each strobe is registered and is
  // valid for the whole cycle of the state it belongs to.
  always_comb begin
    busy_d    = (state_d == ST_CAPT) || (state_d == ST_SHIFT) || (state_d == ST_UPD);
    capture_d = (state_d == ST_CAPT);
    shift_d   = (state_d == ST_SHIFT);
    update_d  = (state_d == ST_UPD);
    done_d    = (state_d == ST_DONE);
    in_en_d   = busy_d & ~dir_d;
    out_en_d  = busy_d & dir_d;
    si_d      = shift_d & sreg_d[0];
  end

  // State register.
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output flops; reset drops every strobe at once.
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      cnt_q     <= '0;
      sreg_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      dir_q     <= 1'b0;
      capture_q <= 1'b0;
      shift_q   <= 1'b0;
      update_q  <= 1'b0;
      in_en_q   <= 1'b0;
      out_en_q  <= 1'b0;
      si_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      dir_q     <= dir_d;
      capture_q <= capture_d;
      shift_q   <= shift_d;
      update_q  <= update_d;
      in_en_q   <= in_en_d;
      out_en_q  <= out_en_d;
      si_q      <= si_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign chain_si           = si_q;
  assign TDR_CAPTURE        = capture_q;
  assign TDR_SHIFT          = shift_q;
  assign TDR_UPDATE         = update_q;
  assign INSCANWRAP_TDR_EN  = in_en_q;
  assign OUTSCANWRAP_TDR_EN = out_en_q;
  assign rdata              = rdata_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule
